// File: rtl/axis_matrix_streamer.sv
// axis_matrix_streamer
//   Host-side AXI4-Stream partner of the systolic-array accelerator.
//   Operand matrices A and B are held in local registers and written
//   through a small configuration port.
//   On start, the block streams ROWS beats of {A[k], B[k]} to the
//   accelerator. It then waits for the single result beat, or gives
//   up after TIMEOUT_CYC idle cycles.
//   Optional feature macro: MATSTREAM_TLAST_EN. It adds the ports
//   m_axis_last and s_axis_last, and with it only a result beat
//   carrying last=1 is captured.
module axis_matrix_streamer #(
  parameter int ROWS        = 4,
  parameter int LANE_W      = 32,
  parameter int RES_W       = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst_n,
  input  logic                    cfg_we,
  input  logic                    cfg_sel,
  input  logic [$clog2(ROWS)-1:0] cfg_addr,
  input  logic [LANE_W-1:0]       cfg_wdata,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [RES_W-1:0]        res_data,
  output logic                    m_axis_valid,
  output logic [2*LANE_W-1:0]     m_axis_data,
  input  logic                    m_axis_ready,
`ifdef MATSTREAM_TLAST_EN
  output logic                    m_axis_last,
  input  logic                    s_axis_last,
`endif
  input  logic                    s_axis_valid,
  input  logic [RES_W-1:0]        s_axis_data,
  output logic                    s_axis_ready
);

  localparam int            AW       = $clog2(ROWS);
  localparam logic [AW-1:0] LAST_K   = AW'(ROWS - 1);
  localparam logic [AW:0]   ROWS_EXT = (AW + 1)'(ROWS);
  localparam logic [7:0]    TO_LIM   = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RES
  } state_t;

  state_t              state;
  logic [LANE_W-1:0]   a_mem [ROWS];
  logic [LANE_W-1:0]   b_mem [ROWS];
  logic [AW-1:0]       k;
  logic [7:0]          wait_cnt;

  logic                wr_en;
  logic                res_capture;
  logic [AW-1:0]       k_inc;
  logic [7:0]          wait_inc;
  logic [LANE_W-1:0]   a0_fwd;
  logic [LANE_W-1:0]   b0_fwd;

  // Operands may only change while idle, so a transfer always sees a frozen matrix.
  assign wr_en    = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < ROWS_EXT);
  assign k_inc    = k + 1'b1;
  assign wait_inc = wait_cnt + 8'd1;

`ifdef MATSTREAM_TLAST_EN
  assign res_capture = s_axis_valid && s_axis_last;
`else
  assign res_capture = s_axis_valid;
`endif

  // Forward a same-cycle write of lane 0 so that a start issued together with it sends the new value.
  always_comb begin
    a0_fwd = a_mem[0];
    b0_fwd = b_mem[0];
    if (wr_en && (cfg_addr == '0)) begin
      if (cfg_sel) b0_fwd = cfg_wdata;
      else         a0_fwd = cfg_wdata;
    end
  end

  // Operand register file: one A row or B column written per strobe.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (wr_en) begin
      if (cfg_sel) b_mem[cfg_addr] <= cfg_wdata;
      else         a_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // Transfer FSM with registered stream/status outputs.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state        <= IDLE;
      k            <= '0;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      res_data     <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      s_axis_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND;
            busy         <= 1'b1;
            done         <= 1'b0;
            timeout      <= 1'b0;
            k            <= '0;
            wait_cnt     <= '0;
            m_axis_valid <= 1'b1;
            m_axis_data  <= {a0_fwd, b0_fwd};
          end
        end
        SEND: begin
          if (m_axis_valid && m_axis_ready) begin
            if (k == LAST_K) begin
              m_axis_valid <= 1'b0;
              s_axis_ready <= 1'b1;
              wait_cnt     <= '0;
              state        <= WAIT_RES;
            end else begin
              k           <= k_inc;
              m_axis_data <= {a_mem[k_inc], b_mem[k_inc]};
            end
          end
        end
        WAIT_RES: begin
          if (res_capture) begin
            res_data     <= s_axis_data;
            done         <= 1'b1;
            busy         <= 1'b0;
            s_axis_ready <= 1'b0;
            state        <= IDLE;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == TO_LIM) begin
              timeout      <= 1'b1;
              done         <= 1'b1;
              busy         <= 1'b0;
              s_axis_ready <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          m_axis_valid <= 1'b0;
          s_axis_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATSTREAM_TLAST_EN
  // Last-beat flag travels with the final beat and holds with it under backpressure.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      m_axis_last <= 1'b0;
    end else if ((state == IDLE) && start) begin
      m_axis_last <= (LAST_K == '0);
    end else if ((state == SEND) && m_axis_valid && m_axis_ready) begin
      m_axis_last <= (k != LAST_K) && (k_inc == LAST_K);
    end
  end
`endif

endmodule

// File: tb/tb_axis_matrix_streamer.sv
// tb_axis_matrix_streamer
//   Table-driven bench for axis_matrix_streamer.
//   Each record carries the operands to load, the per-cycle ready pattern, the
//   expected beats, the expected length of the SEND phase and the result beat
//   to return.
//   Hand-written sequences follow the table. They cover timeout, ignored
//   start/write during a transfer, start together with a write, and reset in
//   the middle of a transfer.
module tb_axis_matrix_streamer;

  logic         axi_clk = 1'b0;
  logic         axi_rst_n;
  logic         cfg_we;
  logic         cfg_sel;
  logic [1:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         start;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [127:0] res_data;
  logic         m_axis_valid;
  logic [63:0]  m_axis_data;
  logic         m_axis_ready;
  logic         s_axis_valid;
  logic [127:0] s_axis_data;
  logic         s_axis_ready;
`ifdef MATSTREAM_TLAST_EN
  logic         m_axis_last;
  logic         s_axis_last;
`endif

  axis_matrix_streamer dut (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .res_data     (res_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready),
`ifdef MATSTREAM_TLAST_EN
    .m_axis_last  (m_axis_last),
    .s_axis_last  (s_axis_last),
`endif
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_ready (s_axis_ready)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct packed {
    logic [3:0][31:0]  a;
    logic [3:0][31:0]  b;
    logic [15:0]       mask;
    int                exp_cyc;
    logic [3:0][63:0]  beat;
    logic [127:0]      res;
  } vec_t;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [127:0] model_res;
  vec_t         tbl [3];
  vec_t         v;
  int           waited;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic writeOp(input logic sel, input logic [1:0] addr, input logic [31:0] wd);
    @(negedge axi_clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = wd;
    @(negedge axi_clk);
    cfg_we    = 1'b0;
  endtask

  task automatic loadOperands(input vec_t r);
    for (int i = 0; i < 4; i++) begin
      writeOp(1'b0, i[1:0], r.a[i]);
      writeOp(1'b1, i[1:0], r.b[i]);
    end
  endtask

  task automatic startPulse(input logic we, input logic sel, input logic [1:0] addr, input logic [31:0] wd);
    @(negedge axi_clk);
    checkOutput("pre_start_valid", 128'(m_axis_valid), 128'(0));
    start     = 1'b1;
    cfg_we    = we;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = wd;
    @(negedge axi_clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    checkOutput("start_busy",        128'(busy),         128'(1));
    checkOutput("start_valid",       128'(m_axis_valid), 128'(1));
    checkOutput("start_done_clr",    128'(done),         128'(0));
    checkOutput("start_timeout_clr", 128'(timeout),      128'(0));
    checkOutput("start_s_ready",     128'(s_axis_ready), 128'(0));
  endtask

  task automatic streamBeats(input vec_t r);
    int          nb;
    int          cyc;
    logic        rdy;
    logic        stalled;
    logic [63:0] prev_data;
    nb        = 0;
    cyc       = 0;
    stalled   = 1'b0;
    prev_data = '0;
    while (nb < 4 && cyc < 64) begin
      rdy = (cyc < 16) ? r.mask[cyc[3:0]] : 1'b1;
      m_axis_ready = rdy;
      if (stalled) begin
        checkOutput("stall_valid", 128'(m_axis_valid), 128'(1));
        checkOutput("stall_data",  128'(m_axis_data),  128'(prev_data));
      end
      if (m_axis_valid && rdy) begin
        checkOutput($sformatf("beat%0d", nb), 128'(m_axis_data), 128'(r.beat[nb[1:0]]));
`ifdef MATSTREAM_TLAST_EN
        checkOutput($sformatf("m_last%0d", nb), 128'(m_axis_last), 128'(nb == 3));
`endif
        nb++;
      end
      stalled   = m_axis_valid && !rdy;
      prev_data = m_axis_data;
      cyc++;
      @(negedge axi_clk);
    end
    m_axis_ready = 1'b0;
    checkOutput("beat_count",   128'(nb),           128'(4));
    checkOutput("send_cycles",  128'(cyc),          128'(r.exp_cyc));
    checkOutput("valid_after",  128'(m_axis_valid), 128'(0));
    checkOutput("busy_wait",    128'(busy),         128'(1));
    checkOutput("s_ready_wait", 128'(s_axis_ready), 128'(1));
`ifdef MATSTREAM_TLAST_EN
    checkOutput("m_last_after", 128'(m_axis_last),  128'(0));
`endif
  endtask

  task automatic finishResult(input logic [127:0] res);
`ifdef MATSTREAM_TLAST_EN
    s_axis_valid = 1'b1;
    s_axis_data  = ~res;
    s_axis_last  = 1'b0;
    @(negedge axi_clk);
    checkOutput("nolast_done",    128'(done),         128'(0));
    checkOutput("nolast_s_ready", 128'(s_axis_ready), 128'(1));
    checkOutput("nolast_res",     res_data,           model_res);
    s_axis_last  = 1'b1;
`endif
    s_axis_valid = 1'b1;
    s_axis_data  = res;
    @(negedge axi_clk);
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
`ifdef MATSTREAM_TLAST_EN
    s_axis_last  = 1'b0;
`endif
    model_res = res;
    checkOutput("res_data",    res_data,           model_res);
    checkOutput("res_done",    128'(done),         128'(1));
    checkOutput("res_timeout", 128'(timeout),      128'(0));
    checkOutput("res_s_ready", 128'(s_axis_ready), 128'(0));
    checkOutput("res_busy",    128'(busy),         128'(0));
  endtask

  task automatic applyStimulus(input vec_t r);
    loadOperands(r);
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    streamBeats(r);
    finishResult(r.res);
  endtask

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus: reset, table of transfers, then multi-cycle corner cases.
  initial begin
    axi_rst_n    = 1'b0;
    cfg_we       = 1'b0;
    cfg_sel      = 1'b0;
    cfg_addr     = 2'd0;
    cfg_wdata    = 32'h0;
    start        = 1'b0;
    m_axis_ready = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
`ifdef MATSTREAM_TLAST_EN
    s_axis_last  = 1'b0;
`endif
    model_res    = '0;

    tbl[0]         = '0;
    tbl[0].a[0]    = 32'h04030201;
    tbl[0].a[1]    = 32'h08070605;
    tbl[0].a[2]    = 32'h0C0B0A09;
    tbl[0].a[3]    = 32'h100F0E0D;
    tbl[0].b[0]    = 32'h01010101;
    tbl[0].b[1]    = 32'h01010101;
    tbl[0].b[2]    = 32'h01010101;
    tbl[0].b[3]    = 32'h01010101;
    tbl[0].mask    = 16'hFFFF;
    tbl[0].exp_cyc = 4;
    tbl[0].beat[0] = 64'h04030201_01010101;
    tbl[0].beat[1] = 64'h08070605_01010101;
    tbl[0].beat[2] = 64'h0C0B0A09_01010101;
    tbl[0].beat[3] = 64'h100F0E0D_01010101;
    tbl[0].res     = 128'hDEAD0000_00000000_00000000_0000BEEF;

    // Ready pattern 1,0,0,1,0,0,1,0,0,1: accepts at cycles 0,3,6,9.
    tbl[1]         = tbl[0];
    tbl[1].mask    = 16'h0249;
    tbl[1].exp_cyc = 10;
    tbl[1].res     = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    // Ready pattern 0,1,1,0,1,...: accepts at cycles 1,2,4,5.
    tbl[2]         = '0;
    tbl[2].a[0]    = 32'h11111111;
    tbl[2].a[1]    = 32'h22222222;
    tbl[2].a[2]    = 32'h33333333;
    tbl[2].a[3]    = 32'h44444444;
    tbl[2].b[0]    = 32'hAAAAAAAA;
    tbl[2].b[1]    = 32'hBBBBBBBB;
    tbl[2].b[2]    = 32'hCCCCCCCC;
    tbl[2].b[3]    = 32'hDDDDDDDD;
    tbl[2].mask    = 16'hFFF6;
    tbl[2].exp_cyc = 6;
    tbl[2].beat[0] = 64'h11111111_AAAAAAAA;
    tbl[2].beat[1] = 64'h22222222_BBBBBBBB;
    tbl[2].beat[2] = 64'h33333333_CCCCCCCC;
    tbl[2].beat[3] = 64'h44444444_DDDDDDDD;
    tbl[2].res     = 128'hCAFEBABE_00000001_00000002_00000003;

    #12;
    checkOutput("rst_busy",    128'(busy),         128'(0));
    checkOutput("rst_done",    128'(done),         128'(0));
    checkOutput("rst_timeout", 128'(timeout),      128'(0));
    checkOutput("rst_res",     res_data,           128'(0));
    checkOutput("rst_valid",   128'(m_axis_valid), 128'(0));
    checkOutput("rst_data",    128'(m_axis_data),  128'(0));
    checkOutput("rst_s_ready", 128'(s_axis_ready), 128'(0));
    @(negedge axi_clk);
    axi_rst_n = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(tbl[i]);

    // A result beat while idle is not accepted and changes nothing.
    @(negedge axi_clk);
    s_axis_valid = 1'b1;
    s_axis_data  = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
`ifdef MATSTREAM_TLAST_EN
    s_axis_last  = 1'b1;
`endif
    checkOutput("idle_s_ready", 128'(s_axis_ready), 128'(0));
    @(negedge axi_clk);
    s_axis_valid = 1'b0;
`ifdef MATSTREAM_TLAST_EN
    s_axis_last  = 1'b0;
`endif
    checkOutput("idle_drop_res",  res_data,   model_res);
    checkOutput("idle_drop_busy", 128'(busy), 128'(0));
    checkOutput("idle_drop_done", 128'(done), 128'(1));

    // No result returned: expect abort after roughly TIMEOUT_CYC cycles.
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    streamBeats(tbl[2]);
    waited = 0;
    while (!done && waited < 300) begin
      @(negedge axi_clk);
      waited++;
    end
    checkOutput("timeout_window", 128'(waited >= 250 && waited <= 260), 128'(1));
    checkOutput("timeout_flag",   128'(timeout),      128'(1));
    checkOutput("timeout_done",   128'(done),         128'(1));
    checkOutput("timeout_res",    res_data,           model_res);
    checkOutput("timeout_busy",   128'(busy),         128'(0));
    checkOutput("timeout_sready", 128'(s_axis_ready), 128'(0));
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    streamBeats(tbl[2]);
    finishResult(128'h55555555_55555555_55555555_55555555);

    // start and an operand write while sending are ignored.
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    start     = 1'b1;
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = 2'd1;
    cfg_wdata = 32'hFFFFFFFF;
    @(negedge axi_clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    checkOutput("midsend_valid", 128'(m_axis_valid), 128'(1));
    checkOutput("midsend_data",  128'(m_axis_data),  128'(tbl[2].beat[0]));
    streamBeats(tbl[2]);
    start = 1'b1;
    @(negedge axi_clk);
    start = 1'b0;
    checkOutput("waitres_start_busy",   128'(busy),         128'(1));
    checkOutput("waitres_start_sready", 128'(s_axis_ready), 128'(1));
    checkOutput("waitres_start_valid",  128'(m_axis_valid), 128'(0));
    finishResult(128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A);
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    streamBeats(tbl[2]);
    finishResult(128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0);

    // start together with a write of A[0] sends the freshly written value.
    v         = tbl[2];
    v.mask    = 16'hFFFF;
    v.exp_cyc = 4;
    v.beat[0] = 64'hCAFEF00D_AAAAAAAA;
    startPulse(1'b1, 1'b0, 2'd0, 32'hCAFEF00D);
    streamBeats(v);
    finishResult(128'h12345678_12345678_12345678_12345678);

    // Reset in the middle of SEND aborts at once and clears the operands.
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    #2;
    axi_rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 128'(m_axis_valid), 128'(0));
    checkOutput("midrst_busy",  128'(busy),         128'(0));
    checkOutput("midrst_done",  128'(done),         128'(0));
    checkOutput("midrst_res",   res_data,           128'(0));
    checkOutput("midrst_data",  128'(m_axis_data),  128'(0));
    @(negedge axi_clk);
    axi_rst_n = 1'b1;
    model_res = '0;
    checkOutput("postrst_valid", 128'(m_axis_valid), 128'(0));
    v         = '0;
    v.mask    = 16'hFFFF;
    v.exp_cyc = 4;
    startPulse(1'b0, 1'b0, 2'd0, 32'h0);
    streamBeats(v);
    finishResult(128'h87654321_87654321_87654321_87654321);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
